// File: rtl/execute_stage.sv
// execute_stage: operand select, ALU, branch resolve and a radix-2 iterative multiplier
// feeding the EX/MEM register.
module execute_stage #(
    parameter int WIDTH   = 32,
    parameter int REG_IDX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [148:0]     idEx,
    output logic             stall,
    output logic [70:0]      exMem,
    output logic [WIDTH-1:0] branchTarget
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, stateNext;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand, mplier, acc;
    logic               immSrc, branchFlag, memWrite, memToReg, regWrite;
    logic [3:0]         aluControl;
    logic [REG_IDX-1:0] rc;
    logic [WIDTH-1:0]   rd1, rd2, rd3, extendImm, opA, opB, aluOut, result;
    logic               isMul, zero, branchTaken, loadInstr, unusedFields;

    assign immSrc     = idEx[148];
    assign branchFlag = idEx[147];
    assign memWrite   = idEx[146];
    assign memToReg   = idEx[145];
    assign regWrite   = idEx[144];
    assign aluControl = idEx[143:140];
    assign rd1        = idEx[135:104];
    assign rd2        = idEx[99:68];
    assign rc         = idEx[67:64];
    assign rd3        = idEx[63:32];
    assign extendImm  = idEx[31:0];
    assign unusedFields = ^{idEx[139:136], idEx[103:100], rd3[WIDTH-1]};

    assign opA   = rd1;
    assign opB   = immSrc ? extendImm : rd2;
    assign isMul = aluControl == 4'd8;
    // Branch compare uses its own subtractor so it is valid for any aluControl.
    assign zero        = (opA - opB) == '0;
    assign branchTaken = branchFlag & zero & ~isMul;
    assign loadInstr   = (state == IDLE && !isMul) || state == DONE;
    assign result      = state == DONE ? acc : aluOut;
    assign stall = rst & (state == BUSY || (state == IDLE && isMul && en && !flush));

    always_comb begin
        aluOut = opB;
        case (aluControl)
            4'd0:    aluOut = opA + opB;
            4'd1:    aluOut = opA - opB;
            4'd2:    aluOut = opA & opB;
            4'd3:    aluOut = opA | opB;
            4'd4:    aluOut = opA ^ opB;
            4'd5:    aluOut = opA << opB[4:0];
            4'd6:    aluOut = opA >> opB[4:0];
            4'd7:    aluOut = WIDTH'($signed(opA) >>> opB[4:0]);
            default: aluOut = opB;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = isMul ? BUSY : IDLE;
            BUSY:    stateNext = count == LAST ? DONE : BUSY;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            exMem        <= '0;
            branchTarget <= '0;
        end else if (flush) begin
            state        <= IDLE;
            count        <= '0;
            acc          <= '0;
            exMem        <= '0;
            branchTarget <= '0;
        end else if (en) begin
            state <= stateNext;
            if (state == IDLE && isMul) begin
                mcand  <= opA;
                mplier <= opB;
                acc    <= '0;
                count  <= '0;
            end else if (state == BUSY) begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
            // Start and BUSY cycles emit bubbles; DONE emits the held MUL with the product.
            exMem        <= loadInstr ? {branchTaken, regWrite, memToReg, memWrite, rc, result, rd3[30:0]} : '0;
            branchTarget <= loadInstr ? extendImm : '0;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: random and directed stimulus against a cycle-count reference model.
module tb_execute_stage;
    logic         clk = 1'b0;
    logic         rst, en, flush;
    logic [148:0] idEx;
    logic         stall;
    logic [70:0]  exMem;
    logic [31:0]  branchTarget;

    int           total = 0, bad = 0;
    bit           checkOn = 1'b0;
    logic [70:0]  expExMem = '0;
    logic [31:0]  expBt = '0;
    logic         expStall = 1'b0;
    bit           mulActive = 1'b0;
    int           stallLeft = 0;
    logic [31:0]  mulProd = '0;
    logic         lastStall, lastExpStall;

    execute_stage #(.WIDTH(32), .REG_IDX(4)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .idEx(idEx),
        .stall(stall), .exMem(exMem), .branchTarget(branchTarget)
    );

    always #5 clk = ~clk;

    function automatic logic [148:0] mk(input logic imm, bf, mw, mtr, rw, input logic [3:0] op,
                                        input logic [31:0] rd1, rd2, input logic [3:0] rc,
                                        input logic [31:0] rd3, ext);
        return {imm, bf, mw, mtr, rw, op, 4'h0, rd1, 4'h0, rd2, rc, rd3, ext};
    endfunction

    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return 32'($signed(a) >>> b[4:0]);
            default: return b;
        endcase
    endfunction

    function automatic logic [70:0] packOut(input logic [148:0] i, input logic [31:0] res);
        logic [31:0] a, b;
        logic        bt;
        a  = i[135:104];
        b  = i[148] ? i[31:0] : i[99:68];
        bt = i[147] && (a - b) == 32'd0 && i[143:140] != 4'd8;
        return {bt, i[144], i[145], i[146], i[67:64], res, i[62:32]};
    endfunction

    function automatic logic calcStall();
        return rst && ((mulActive && stallLeft > 0) || (!mulActive && idEx[143:140] == 4'd8 && en && !flush));
    endfunction

    task automatic modelReset();
        expExMem  = '0;
        expBt     = '0;
        mulActive = 1'b0;
        stallLeft = 0;
    endtask

    // A MUL stalls for its start cycle plus 32 step cycles, then retires the product.
    task automatic modelEdge();
        logic [31:0] a, b;
        a = idEx[135:104];
        b = idEx[148] ? idEx[31:0] : idEx[99:68];
        if (!rst) modelReset();
        else if (flush) begin
            expExMem = '0; expBt = '0; mulActive = 1'b0;
        end else if (en) begin
            if (mulActive && stallLeft > 0) begin
                stallLeft--; expExMem = '0; expBt = '0;
            end else if (mulActive) begin
                expExMem = packOut(idEx, mulProd); expBt = idEx[31:0]; mulActive = 1'b0;
            end else if (idEx[143:140] == 4'd8) begin
                mulActive = 1'b1; stallLeft = 32; mulProd = a * b; expExMem = '0; expBt = '0;
            end else begin
                expExMem = packOut(idEx, aluRef(idEx[143:140], a, b)); expBt = idEx[31:0];
            end
        end
    endtask

    task automatic check(input string nm, input logic [70:0] act, input logic [70:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (checkOn) begin
            check("exMem", exMem, expExMem);
            check("branchTarget", 71'(branchTarget), 71'(expBt));
            check("stall", 71'(stall), 71'(expStall));
        end
    end

    task automatic cycle(input logic e, input logic f, input logic [148:0] ins);
        @(negedge clk); #2;
        en = e; flush = f; idEx = ins;
        expStall = calcStall();
        lastExpStall = expStall;
        #1 lastStall = stall;
        @(posedge clk);
        modelEdge();
        expStall = calcStall();
        #1;
    endtask

    task automatic asyncReset();
        @(negedge clk); #3;
        rst = 1'b0; en = 1'b0;
        modelReset();
        expStall = calcStall();
        #1;
        check("rstExMem", exMem, 71'(0));
        check("rstStall", 71'(stall), 71'(0));
        check("rstBt", 71'(branchTarget), 71'(0));
        @(negedge clk); #2;
        rst = 1'b1;
        expStall = calcStall();
    endtask

    task automatic runMul(input logic [148:0] ins, input int freezeAt, output int cnt);
        bit done;
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            cycle(1'b1, 1'b0, ins);
            cnt += int'(lastStall);
            if (cnt == freezeAt)
                repeat (4) begin
                    cycle(1'b0, 1'b0, ins);
                    cnt += int'(lastStall);
                end
            done = !lastStall;
        end
        if (!done) check("mulTimeout", 71'(0), 71'(1));
    endtask

    function automatic logic [148:0] randInstr();
        logic [31:0] r1, r2;
        logic [3:0]  op;
        r1 = $urandom;
        r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
        op = ($urandom_range(0, 5) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
        return mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), op,
                  r1, r2, 4'($urandom), $urandom, ($urandom_range(0, 1) == 0) ? r2 : 32'($urandom_range(0, 40)));
    endfunction

    initial begin
        logic [148:0] cur;
        logic         e, f, adv;
        int           cnt;
        rst = 1'b0; en = 1'b0; flush = 1'b0; idEx = '0;
        repeat (2) @(posedge clk);
        #1;
        check("initExMem", exMem, 71'(0));
        check("initStall", 71'(stall), 71'(0));
        check("initBt", 71'(branchTarget), 71'(0));
        @(negedge clk); #2;
        rst = 1'b1;
        expStall = calcStall();
        checkOn = 1'b1;

        // Reset mid-multiply at counter 10, then a plain ADD.
        repeat (11) cycle(1'b1, 1'b0, mk(0, 0, 0, 0, 1, 4'd8, 32'd6, 32'd7, 4'd5, 32'd0, 32'd0));
        check("busyStall", 71'(stall), 71'(1));
        asyncReset();
        cycle(1'b1, 1'b0, mk(0, 0, 0, 0, 1, 4'd0, 32'd5, 32'd7, 4'd3, 32'd0, 32'd0));
        check("addResult", 71'(exMem[62:31]), 71'(12));
        check("addRc", 71'(exMem[66:63]), 71'(3));
        check("addRegWrite", 71'(exMem[69]), 71'(1));

        cycle(1'b1, 1'b0, mk(1, 0, 0, 0, 1, 4'd1, 32'h10, 32'd0, 4'd7, 32'd0, 32'hFFFF_FFFF));
        check("subImm", 71'(exMem[62:31]), 71'(32'h11));
        cycle(1'b1, 1'b0, mk(1, 0, 0, 0, 1, 4'd7, 32'h8000_0000, 32'd0, 4'd2, 32'd0, 32'd4));
        check("sra", 71'(exMem[62:31]), 71'(32'hF800_0000));

        runMul(mk(0, 0, 0, 0, 1, 4'd8, 32'h0000_FFFF, 32'h0001_0001, 4'd9, 32'h1234_5678, 32'd0), -1, cnt);
        check("mulStallCycles", 71'(cnt), 71'(33));
        check("mulProduct", 71'(exMem[62:31]), 71'(32'hFFFF_FFFF));
        check("mulRc", 71'(exMem[66:63]), 71'(9));
        cycle(1'b1, 1'b0, mk(0, 0, 0, 0, 1, 4'd0, 32'd1, 32'd2, 4'd4, 32'd0, 32'd0));
        check("afterMulStall", 71'(lastStall), 71'(0));
        check("afterMulAdd", 71'(exMem[62:31]), 71'(3));

        cycle(1'b1, 1'b0, mk(0, 1, 0, 0, 0, 4'd1, 32'h2A, 32'h2A, 4'd0, 32'd0, 32'h40));
        check("brTaken", 71'(exMem[70]), 71'(1));
        check("brTarget", 71'(branchTarget), 71'(32'h40));
        cycle(1'b1, 1'b0, mk(0, 1, 0, 0, 0, 4'd1, 32'h2A, 32'h2B, 4'd0, 32'd0, 32'h40));
        check("brNotTaken", 71'(exMem[70]), 71'(0));
        asyncReset();

        repeat (6) cycle(1'b1, 1'b0, mk(0, 0, 0, 0, 1, 4'd8, 32'd7, 32'd9, 4'd1, 32'd0, 32'd0));
        cycle(1'b1, 1'b1, mk(0, 0, 0, 0, 1, 4'd8, 32'd7, 32'd9, 4'd1, 32'd0, 32'd0));
        check("flushBubble", exMem, 71'(0));
        check("flushStall", 71'(stall), 71'(0));
        runMul(mk(0, 0, 0, 0, 1, 4'd8, 32'd3, 32'd4, 4'd6, 32'd0, 32'd0), -1, cnt);
        check("mul34Cycles", 71'(cnt), 71'(33));
        check("mul34", 71'(exMem[62:31]), 71'(12));

        runMul(mk(0, 0, 0, 0, 1, 4'd8, 32'h1234, 32'h5678, 4'd2, 32'd0, 32'd0), 10, cnt);
        check("frozenCycles", 71'(cnt), 71'(37));
        check("frozenProduct", 71'(exMem[62:31]), 71'(32'h0626_0060));

        cur = randInstr();
        adv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) begin
                asyncReset();
                adv = 1'b1;
            end
            if (adv) cur = randInstr();
            e = $urandom_range(0, 9) != 0;
            f = $urandom_range(0, 59) == 0;
            cycle(e, f, cur);
            adv = f || (e && !lastExpStall);
        end

        @(negedge clk);
        checkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline stage directly downstream of the ID/EX register. It consumes the 149-bit decoded bundle, selects operands, runs the ALU and resolves branches.
- It owns a multi-cycle iterative multiplier with a stall handshake.
- Results are registered into the EX/MEM pipeline register, which feeds the memory stage.

Parameters:
- WIDTH, 32, datapath width. The bundle layout below is fixed for WIDTH=32.
- REG_IDX, 4, register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  hazard-unit enable; 0 freezes the whole stage, including the FSM.
- flush  in  1  loads a bubble into EX/MEM and aborts any multiply.
- idEx  in  149  ID/EX bundle, MSB first: immSrc[148], branchFlag[147], memWrite[146], memToReg[145], regWrite[144], aluControl[143:140], Ra[139:136], RD1[135:104], Rb[103:100], RD2[99:68], Rc[67:64], RD3[63:32], extendImm[31:0].
- stall  out  1  multiply in progress; upstream must hold ID/EX.
- exMem  out  71  registered: branchTaken[70], regWrite[69], memToReg[68], memWrite[67], Rc[66:63], aluResult[62:31], storeData[30:0]. storeData is RD3[30:0]; RD3[31] is not forwarded.
- branchTarget  out  32  registered extendImm of the branch instruction.

Behaviour:
- Reset (rst=0, async): exMem=0, branchTarget=0, FSM=IDLE, counter=0, stall=0. This applies mid-multiply, which is aborted.
- Operands: opA=RD1; opB = immSrc ? extendImm : RD2.
- aluControl encoding:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = opB[4:0].
  - 8 MUL: low 32 bits of the product, multi-cycle.
  - 9–15: pass opB.
- Arithmetic: wrap-around mod 2^32, no flags exported.
- Branch: branchTaken = branchFlag & (opA−opB == 0), computed by a SUB independent of aluControl, and registered with the instruction.
- Single-cycle ops: with en=1, flush=0 and FSM=IDLE, EX/MEM loads at the next edge. Latency is 1 cycle.
- FSM states: IDLE, BUSY, DONE.
  - IDLE and aluControl=8 and en=1: capture opA/opB into the multiplicand/multiplier registers, clear the accumulator, counter=0, go to BUSY. stall=1 combinationally in this cycle. EX/MEM loads a bubble (all control bits 0, data 0).
  - BUSY: each en=1 cycle performs one radix-2 shift-add step (if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1) and increments the counter. stall=1; EX/MEM loads a bubble. When the counter reaches WIDTH−1 on that step, go to DONE.
  - DONE: stall=0. EX/MEM loads the MUL instruction's control fields with aluResult=acc. Go to IDLE without restarting, even though ID/EX still shows MUL in this cycle.
  - Net effect: stall is high for WIDTH+1 consecutive cycles (33 at WIDTH=32). The product is visible in exMem after edge WIDTH+2, counting the start cycle as 1.
- Priority, highest first: rst > flush > en.
  - flush=1: EX/MEM=bubble, FSM→IDLE, stall=0 next cycle; the accumulator is discarded.
  - en=0 and flush=0: all state and outputs hold. stall keeps its current value.
- A bubble input (all control bits 0, aluControl=0) passes through as a bubble: regWrite=0, memWrite=0, branchTaken=0.
- MUL with branchFlag=1 is illegal; branchTaken is forced to 0 for MUL.

Test Plan:
1. Reset low mid-BUSY (counter=10) → exMem=0, stall=0 immediately (async); after release, an ADD RD1=5, RD2=7, immSrc=0, regWrite=1, Rc=3 gives exMem aluResult=12, Rc=3, regWrite=1 one cycle later.
2. SUB immSrc=1, RD1=0x10, extendImm=0xFFFFFFFF (−1) → aluResult=0x11. SRA with RD1=0x80000000, opB=4 → 0xF8000000.
3. MUL RD1=0xFFFF, RD2=0x10001 → stall=1 for exactly 33 cycles, exMem bubbles meanwhile, then aluResult=0xFFFFFFFF. The next instruction (ADD) follows on the next cycle with no re-issued MUL.
4. Branch: branchFlag=1, RD1=RD2=0x2A, extendImm=0x40 → branchTaken=1, branchTarget=0x40. With RD2=0x2B → branchTaken=0.
5. flush asserted at BUSY step 5 → next exMem is a bubble, stall=0. A subsequent MUL 3×4 restarts cleanly and yields 12.
6. en=0 for 4 cycles during BUSY → counter and exMem frozen; the product is correct and the stall total equals 33 + 4 cycles.
